// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width and the 4-bit control codes driven on alu_ctrl.
package alu_pkg;

  localparam int N = 32;

  // Codes 1001-1111 are illegal; the issue stage passes them through untouched.
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_NOR = 4'b0100,
    ALU_XOR = 4'b0101,
    ALU_SLL = 4'b0110,
    ALU_SRL = 4'b0111,
    ALU_SRA = 4'b1000
  } alu_op_e;

endpackage

// File: rtl/fwd_mux.sv
// Resolves one source operand: EX/MEM forward, else MEM/WB forward, else register file.
module fwd_mux #(
  parameter int N  = alu_pkg::N,
  parameter int RW = 4
) (
  input  logic [RW-1:0] rs,
  input  logic [N-1:0]  rf_data,
  input  logic          ex_wr,
  input  logic [RW-1:0] ex_rd,
  input  logic [N-1:0]  ex_result,
  input  logic          wb_wr,
  input  logic [RW-1:0] wb_rd,
  input  logic [N-1:0]  wb_result,
  output logic [N-1:0]  data
);

  always_comb begin
    data = rf_data;
    // Register 0 is hardwired to zero and never forwarded; the younger EX result wins.
    if (rs == '0)
      data = '0;
    else if (ex_wr && (ex_rd == rs))
      data = ex_result;
    else if (wb_wr && (wb_rd == rs))
      data = wb_result;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: operand forwarding, load-use stall and the register feeding the ALU.
module alu_issue_stage #(
  parameter int N  = alu_pkg::N,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_op,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic [N-1:0]  in_rs1_data,
  input  logic [N-1:0]  in_rs2_data,
  input  logic [N-1:0]  in_imm,
  input  logic          in_use_imm,
  input  logic [RW-1:0] in_rd,
  input  logic          in_wr,
  input  logic          in_is_load,
  input  logic          flush,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_wr,
  input  logic          ex_is_load,
  input  logic [N-1:0]  ex_result,
  input  logic [RW-1:0] wb_rd,
  input  logic          wb_wr,
  input  logic [N-1:0]  wb_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [3:0]    alu_ctrl,
  output logic [RW-1:0] out_rd,
  output logic          out_wr,
  output logic          out_is_load
);

  import alu_pkg::*;

  logic [N-1:0] rs1_val;
  logic [N-1:0] rs2_val;
  logic [N-1:0] b_val;
  logic         hazard;
  logic         capture;
  logic         valid_d;

  fwd_mux #(.N(N), .RW(RW)) u_fwd_a (
    .rs        (in_rs1),
    .rf_data   (in_rs1_data),
    .ex_wr     (ex_wr),
    .ex_rd     (ex_rd),
    .ex_result (ex_result),
    .wb_wr     (wb_wr),
    .wb_rd     (wb_rd),
    .wb_result (wb_result),
    .data      (rs1_val)
  );

  fwd_mux #(.N(N), .RW(RW)) u_fwd_b (
    .rs        (in_rs2),
    .rf_data   (in_rs2_data),
    .ex_wr     (ex_wr),
    .ex_rd     (ex_rd),
    .ex_result (ex_result),
    .wb_wr     (wb_wr),
    .wb_rd     (wb_rd),
    .wb_result (wb_result),
    .data      (rs2_val)
  );

  always_comb begin
    b_val   = in_use_imm ? in_imm : rs2_val;
    // A load in EX has no data yet; rs2 only matters when B actually comes from it.
    hazard  = in_valid && ex_is_load && ex_wr && (ex_rd != '0) &&
              ((ex_rd == in_rs1) || ((ex_rd == in_rs2) && !in_use_imm));
    in_ready = !rst && !hazard && (!out_valid || out_ready);
    capture  = in_valid && in_ready && !flush;

    valid_d = out_valid;
    if (flush)
      valid_d = 1'b0;
    else if (capture)
      valid_d = 1'b1;
    else if (out_ready)
      valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= ALU_ADD;
      out_rd      <= '0;
      out_wr      <= 1'b0;
      out_is_load <= 1'b0;
    end else begin
      out_valid <= valid_d;
      if (capture) begin
        alu_a       <= rs1_val;
        alu_b       <= b_val;
        alu_ctrl    <= in_op;
        out_rd      <= in_rd;
        out_wr      <= in_wr;
        out_is_load <= in_is_load;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed test-plan cases then randomized traffic.
module tb_alu_issue_stage;

  localparam int N  = 32;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [RW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [N-1:0]  in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic          in_use_imm = 1'b0, in_wr = 1'b0, in_is_load = 1'b0;
  logic          flush = 1'b0;
  logic [RW-1:0] ex_rd = '0, wb_rd = '0;
  logic          ex_wr = 1'b0, ex_is_load = 1'b0, wb_wr = 1'b0;
  logic [N-1:0]  ex_result = '0, wb_result = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  alu_a, alu_b;
  logic [3:0]    alu_ctrl;
  logic [RW-1:0] out_rd;
  logic          out_wr, out_is_load;

  alu_issue_stage #(.N(N), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd), .in_wr(in_wr),
    .in_is_load(in_is_load), .flush(flush),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .wb_rd(wb_rd), .wb_wr(wb_wr), .wb_result(wb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .out_rd(out_rd), .out_wr(out_wr), .out_is_load(out_is_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic [3:0]    ctrl;
    logic [RW-1:0] rd;
    logic          wr;
    logic          ld;
  } item_t;

  item_t       q[$];
  int unsigned total  = 0;
  int unsigned passed = 0;
  logic        exp_ready = 1'b0;
  logic        chk_rst   = 1'b0;
  logic        mon_en    = 1'b0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Architectural operand value seen by an instruction issued with the current bypass state.
  function automatic logic [N-1:0] resolve(input logic [RW-1:0] rs, input logic [N-1:0] rf);
    if (rs == 0) return '0;
    if (ex_wr && ex_rd == rs) return ex_result;
    if (wb_wr && wb_rd == rs) return wb_result;
    return rf;
  endfunction

  // One clock of stimulus: inputs already applied; update the reference queue after the edge decision.
  task automatic step();
    logic  hz;
    logic  cap;
    item_t it;
    hz = in_valid && ex_is_load && ex_wr && (ex_rd != 0) &&
         ((ex_rd == in_rs1) || (ex_rd == in_rs2 && !in_use_imm));
    exp_ready = !rst && !hz && (q.size() == 0 || out_ready);
    cap = !rst && !flush && in_valid && exp_ready;
    it.a    = resolve(in_rs1, in_rs1_data);
    it.b    = in_use_imm ? in_imm : resolve(in_rs2, in_rs2_data);
    it.ctrl = in_op;
    it.rd   = in_rd;
    it.wr   = in_wr;
    it.ld   = in_is_load;
    @(negedge clk); #1;
    if (rst || flush) q.delete();
    if (cap) q.push_back(it);
    chk_rst = rst;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; in_valid = 0; out_ready = 1;
    in_op = 0; in_rs1 = 0; in_rs2 = 0; in_rs1_data = 0; in_rs2_data = 0;
    in_imm = 0; in_use_imm = 0; in_rd = 0; in_wr = 0; in_is_load = 0;
    ex_rd = 0; ex_wr = 0; ex_is_load = 0; ex_result = 0;
    wb_rd = 0; wb_wr = 0; wb_result = 0;
  endtask

  // Monitor: compares handshake and presented instruction against the reference queue.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, q.size() != 0);
      if (chk_rst) begin
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_ctrl", alu_ctrl, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_wr", out_wr, 0);
        chk("rst_ld", out_is_load, 0);
      end
      if (q.size() != 0) begin
        chk("alu_a", alu_a, q[0].a);
        chk("alu_b", alu_b, q[0].b);
        chk("alu_ctrl", alu_ctrl, q[0].ctrl);
        chk("out_rd", out_rd, q[0].rd);
        chk("out_wr", out_wr, q[0].wr);
        chk("out_is_load", out_is_load, q[0].ld);
        if (out_ready && !flush && !rst) void'(q.pop_front());
      end
    end
  end

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    mon_en = 1;
    step();
    step();
    idle();

    // Plain ADD, no forwarding
    in_valid = 1; in_op = 4'b0000; in_rs1 = 1; in_rs1_data = 5; in_rs2 = 2; in_rs2_data = 7;
    in_rd = 6; in_wr = 1;
    step();
    chk("add_valid", out_valid, 1);
    chk("add_a", alu_a, 5);
    chk("add_b", alu_b, 7);
    chk("add_ctrl", alu_ctrl, 0);

    // EX beats WB, then WB alone
    idle();
    in_valid = 1; in_rs1 = 3; in_rs1_data = 32'h77;
    ex_wr = 1; ex_rd = 3; ex_result = 32'h10; wb_wr = 1; wb_rd = 3; wb_result = 32'h20;
    step();
    chk("fwd_ex", alu_a, 32'h10);
    ex_wr = 0;
    step();
    chk("fwd_wb", alu_a, 32'h20);

    // r0 never forwarded
    idle();
    in_valid = 1; in_rs1 = 0; in_rs1_data = 32'h55; ex_wr = 1; ex_rd = 0; ex_result = 32'h99;
    step();
    chk("r0_zero", alu_a, 0);

    // Load-use: one bubble, then the load value arrives via WB
    idle();
    step();
    in_valid = 1; in_rs1 = 1; in_rs1_data = 1; in_rs2 = 4; in_rs2_data = 32'hDEAD;
    ex_is_load = 1; ex_wr = 1; ex_rd = 4;
    #1 chk("lu_stall", in_ready, 0);
    step();
    ex_is_load = 0; ex_wr = 0; wb_wr = 1; wb_rd = 4; wb_result = 32'hAB;
    #1 chk("lu_resume", in_ready, 1);
    step();
    chk("lu_b", alu_b, 32'hAB);
    wb_wr = 0; ex_is_load = 1; ex_wr = 1; ex_rd = 4; in_use_imm = 1; in_imm = 32'h33;
    #1 chk("lu_imm_nostall", in_ready, 1);
    step();
    chk("lu_imm_b", alu_b, 32'h33);

    // Backpressure hold, then back-to-back
    idle();
    in_valid = 1; in_op = 4'b0101; in_rs1 = 1; in_rs1_data = 32'h1234;
    step();
    out_ready = 0; in_rs1 = 2; in_rs1_data = 32'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_ready", in_ready, 0);
      chk("hold_a", alu_a, 32'h1234);
    end
    out_ready = 1;
    step();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_a", alu_a, 32'h99);

    // Flush with incoming transfer while full
    out_ready = 0; flush = 1;
    step();
    chk("flush_valid", out_valid, 0);

    // Reset while stalled
    idle();
    in_valid = 1; in_op = 4'b1111; in_rs1 = 5; in_rs1_data = 32'hCAFE; in_rd = 9; in_wr = 1; in_is_load = 1;
    step();
    out_ready = 0; rst = 1;
    step();
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_a", alu_a, 0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      in_valid    = ($urandom_range(0, 3) != 0);
      in_op       = 4'($urandom_range(0, 15));
      in_rs1      = RW'($urandom_range(0, 5));
      in_rs2      = RW'($urandom_range(0, 5));
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      in_imm      = $urandom;
      in_use_imm  = ($urandom_range(0, 2) == 0);
      in_rd       = RW'($urandom_range(0, 15));
      in_wr       = 1'($urandom_range(0, 1));
      in_is_load  = 1'($urandom_range(0, 1));
      ex_rd       = RW'($urandom_range(0, 5));
      ex_wr       = 1'($urandom_range(0, 1));
      ex_is_load  = ($urandom_range(0, 2) == 0);
      ex_result   = $urandom;
      wb_rd       = RW'($urandom_range(0, 5));
      wb_wr       = 1'($urandom_range(0, 1));
      wb_result   = $urandom;
      step();
    end

    idle();
    step();
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
